// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: walks one column per scan tick, classifies each
// 4-column frame and debounces presses and releases into a single accepted key code.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] value,
    output logic       valid,
    output logic       pressed
);

    localparam int         DIV_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] DB_CNT = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    logic [3:0]       rs_meta_q, rs_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       ci_q, ci_d;
    logic             tick, frame_end;

    // Row synchroniser and scan timebase.
    // NOTE: sequential state is always written with non-blocking assignments so every
    // flop samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
            div_q     <= '0;
            ci_q      <= '0;
        end else begin
            rs_meta_q <= row;
            rs_q      <= rs_meta_q;
            div_q     <= div_d;
            ci_q      <= ci_d;
        end
    end

    assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end = tick && (ci_q == 2'd3);
    assign div_d     = tick ? '0 : div_q + 1'b1;
    assign ci_d      = tick ? ci_q + 2'd1 : ci_q;
    assign col       = ~(4'b0001 << ci_q);

    // Classify the rows seen on the currently driven column.
    logic [3:0] low;
    logic [2:0] n_low;
    logic [1:0] row_idx;
    logic       col_hit, col_multi;

    assign low       = ~rs_q;
    assign n_low     = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
    assign col_hit   = (n_low == 3'd1);
    assign col_multi = (n_low >= 3'd2);

    // NOTE: every signal driven from always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        row_idx = 2'd0;
        case (low)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Frame accumulators: hit count saturates at 2, since two hits already means MULTI.
    logic [1:0] hit_n_q, hit_n_sum;
    logic [3:0] hit_code_q, frame_code;
    logic       multi_q, multi_sum;
    logic       frame_none, frame_key;

    assign hit_n_sum  = (col_hit && hit_n_q != 2'd2) ? hit_n_q + 2'd1 : hit_n_q;
    assign multi_sum  = multi_q | col_multi;
    assign frame_code = col_hit ? {row_idx, ci_q} : hit_code_q;
    assign frame_none = frame_end && (hit_n_sum == 2'd0) && !multi_sum;
    assign frame_key  = frame_end && (hit_n_sum == 2'd1) && !multi_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_n_q    <= '0;
            hit_code_q <= '0;
            multi_q    <= 1'b0;
        end else if (frame_end) begin
            hit_n_q    <= '0;
            hit_code_q <= '0;
            multi_q    <= 1'b0;
        end else if (tick) begin
            hit_n_q <= hit_n_sum;
            multi_q <= multi_sum;
            if (col_hit) begin
                hit_code_q <= {row_idx, ci_q};
            end
        end
    end

    // Debounce FSM; all transitions happen only at frame end.
    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       pressed_q, pressed_d;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_key) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            value_d   = frame_code;
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = S_HELD;
                        end else begin
                            state_d = S_PRESS_DB;
                        end
                    end
                end
                S_PRESS_DB: begin
                    if (frame_key && frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_CNT) begin
                            value_d   = cand_q;
                            valid_d   = 1'b1;
                            pressed_d = 1'b1;
                            state_d   = S_HELD;
                        end
                    end else if (frame_key) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    // Any non-NONE frame, even a different key, keeps the held key.
                    if (frame_none) begin
                        cnt_d = 4'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            pressed_d = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = S_REL_DB;
                        end
                    end
                end
                S_REL_DB: begin
                    if (frame_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_CNT) begin
                            pressed_d = 1'b0;
                            state_d   = S_IDLE;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign value   = value_q;
    assign valid   = valid_q;
    assign pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a matrix model drives rows from col, expected
// accepted codes are queued by the stimulus and popped by a monitor on each valid pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col, value;
    logic        valid, pressed;
    logic [15:0] keys = '0;
    logic [3:0]  exp_q[$];
    logic        prev_valid = 1'b0;
    int          total = 0;
    int          bad = 0;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row    (row),
        .col    (col),
        .value  (value),
        .valid  (valid),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    // Key k = r*4 + c pulls row r low only while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(keys[r*4 +: 4] & ~col);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued code.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            check("valid_width", int'(prev_valid), 0);
            check("valid_while_pressed_before", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("valid_value", int'(value), int'(e));
            end else begin
                $display("FAIL unexpected_valid: got value %0d expected no pulse", value);
            end
        end
        prev_valid = rst_n && valid;
    end

    task automatic wait_col(input logic [3:0] target);
        int g;
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (col !== target && g < 40);
        if (col !== target) begin
            total++;
            bad++;
            $display("FAIL col_wait: got %b expected %b", col, target);
        end
    endtask

    // Advance to the start of the n-th following frame (just after its opening edge).
    task automatic frames(input int n);
        repeat (n) begin
            wait_col(4'b0111);
            wait_col(4'b1110);
        end
    endtask

    initial begin
        logic [3:0] e;
        #12;
        check("rst_col", int'(col), 4'b1110);
        check("rst_value", int'(value), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_pressed", int'(pressed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            repeat (SCAN_DIV) @(posedge clk);
            #1;
            e = ~(4'b0001 << (i % 4));
            check("col_step", int'(col), int'(e));
        end

        // Clean press of key 9, held 6 frames, then released.
        keys = 16'(1) << 9;
        frames(2);
        check("press9_not_yet", int'(pressed), 0);
        exp_q.push_back(4'd9);
        frames(1);
        check("press9_pressed", int'(pressed), 1);
        check("press9_value", int'(value), 9);
        frames(3);
        keys = '0;
        frames(2);
        check("rel9_still_held", int'(pressed), 1);
        frames(1);
        check("rel9_pressed", int'(pressed), 0);
        check("rel9_value_kept", int'(value), 9);

        // Bounce on key 3: 2 present, 1 absent, 3 present.
        keys = 16'(1) << 3;
        frames(2);
        keys = '0;
        frames(1);
        check("bounce_no_accept", int'(pressed), 0);
        keys = 16'(1) << 3;
        frames(2);
        check("bounce_not_yet", int'(pressed), 0);
        exp_q.push_back(4'd3);
        frames(1);
        check("bounce_pressed", int'(pressed), 1);
        check("bounce_value", int'(value), 3);
        keys = '0;
        frames(3);
        check("bounce_released", int'(pressed), 0);

        // Two keys on one row: MULTI, then the remaining key is accepted.
        keys = (16'(1) << 4) | (16'(1) << 6);
        frames(5);
        check("multi_no_press", int'(pressed), 0);
        check("multi_value_kept", int'(value), 3);
        keys = 16'(1) << 4;
        frames(2);
        exp_q.push_back(4'd4);
        frames(1);
        check("multi_then4_pressed", int'(pressed), 1);
        check("multi_then4_value", int'(value), 4);
        keys = '0;
        frames(3);
        check("multi_released", int'(pressed), 0);

        // Key 5 accepted, direct change to key 10 is ignored while held.
        keys = 16'(1) << 5;
        frames(2);
        exp_q.push_back(4'd5);
        frames(1);
        check("chg5_value", int'(value), 5);
        keys = 16'(1) << 10;
        frames(3);
        check("chg10_still_pressed", int'(pressed), 1);
        check("chg10_value_kept", int'(value), 5);
        keys = '0;
        frames(3);
        check("chg_released", int'(pressed), 0);
        keys = 16'(1) << 10;
        frames(2);
        exp_q.push_back(4'd10);
        frames(1);
        check("chg10_pressed", int'(pressed), 1);
        check("chg10_value", int'(value), 10);
        keys = '0;
        frames(3);

        // Release glitch on key 7.
        keys = 16'(1) << 7;
        frames(2);
        exp_q.push_back(4'd7);
        frames(2);
        keys = '0;
        frames(2);
        keys = 16'(1) << 7;
        frames(1);
        check("glitch_still_pressed", int'(pressed), 1);
        check("glitch_value", int'(value), 7);
        keys = '0;
        frames(2);
        check("glitch_rel_partial", int'(pressed), 1);
        frames(1);
        check("glitch_released", int'(pressed), 0);

        // Asynchronous reset in the middle of a held key.
        keys = 16'(1) << 5;
        frames(2);
        exp_q.push_back(4'd5);
        frames(1);
        check("midrst_pre_pressed", int'(pressed), 1);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_col", int'(col), 4'b1110);
        check("midrst_value", int'(value), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_pressed", int'(pressed), 0);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        frames(2);
        check("after_rst_pressed", int'(pressed), 0);
        repeat (20) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
